// File: rtl/ula_mdu_control_pkg.sv
// ula_mdu_control_pkg: shared opcodes, decode constants and FSM states for the ALU-control / MDU block.
package ula_mdu_control_pkg;
    typedef enum logic [3:0] {
        ULA_AND = 4'b0000,
        ULA_OR  = 4'b0001,
        ULA_ADD = 4'b0010,
        ULA_SUB = 4'b0110,
        ULA_INV = 4'b1111
    } ula_op_t;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } mop_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_OR     = 3'b110;
endpackage

// File: rtl/ula_mdu_control_if.sv
// ula_mdu_control_if: instruction fields and operands in, decode/MDU status and result out.
interface ula_mdu_control_if #(
    parameter int XLEN = 32
);
    logic [1:0]      ALUOp;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            start;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [3:0]      ula_op;
    logic            mdu_sel;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] mdu_result;

    modport master (
        output ALUOp, funct3, funct7, start, op_a, op_b,
        input  ula_op, mdu_sel, stall, busy, done, mdu_result
    );
    modport slave (
        input  ALUOp, funct3, funct7, start, op_a, op_b,
        output ula_op, mdu_sel, stall, busy, done, mdu_result
    );
endinterface

// File: rtl/ula_mdu_core.sv
// ula_mdu_core: radix-2 shift-add multiplier / restoring divider on magnitudes with sign fix-up.
// ULA_MDU_SHORTCUT_EN adds a combinational result for trivially resolvable ops.
module ula_mdu_core
    import ula_mdu_control_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_last,
    output logic            o_fast,
    output logic [XLEN-1:0] o_result,
    output logic [XLEN-1:0] o_fast_result
);
    localparam int CW = $clog2(XLEN);

    logic [2:0]        r_op;
    logic              r_neg, r_a_neg, r_dz;
    logic [XLEN-1:0]   r_a, r_b, r_hi, r_lo;
    logic [CW-1:0]     r_cnt;
    logic              w_an, w_bn;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_hi_n, w_lo_n, w_q, w_r;
    logic [XLEN:0]     w_sum, w_rem_t, w_diff;
    logic [2*XLEN-1:0] w_prod;

    assign w_an    = (i_op inside {M_MULH, M_MULHSU, M_DIV, M_REM}) && i_a[XLEN-1];
    assign w_bn    = (i_op inside {M_MULH, M_DIV, M_REM}) && i_b[XLEN-1];
    assign w_mag_a = w_an ? -i_a : i_a;
    assign w_mag_b = w_bn ? -i_b : i_b;

    // r_hi:r_lo is the product register for multiply and remainder:dividend/quotient for divide
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_rem_t = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_rem_t - {1'b0, r_b};
    assign w_hi_n  = r_op[2] ? (w_diff[XLEN] ? w_rem_t[XLEN-1:0] : w_diff[XLEN-1:0]) : w_sum[XLEN:1];
    assign w_lo_n  = r_op[2] ? {r_lo[XLEN-2:0], ~w_diff[XLEN]} : {w_sum[0], r_lo[XLEN-1:1]};

    assign w_prod   = r_neg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
    assign w_q      = r_dz ? '1 : (r_neg ? -w_lo_n : w_lo_n);
    assign w_r      = r_dz ? r_a : (r_a_neg ? -w_hi_n : w_hi_n);
    assign o_result = r_op == M_MUL ? w_prod[XLEN-1:0] : !r_op[2] ? w_prod[2*XLEN-1:XLEN] : r_op[1] ? w_r : w_q;
    assign o_last   = i_step && r_cnt == CW'(XLEN - 1);

`ifdef ULA_MDU_SHORTCUT_EN
    logic w_ovf;
    assign w_ovf         = (i_op == M_DIV || i_op == M_REM) && i_a == {1'b1, {(XLEN-1){1'b0}}} && i_b == '1;
    assign o_fast        = i_op[2] ? (i_b == '0 || w_ovf) : (i_a == '0 || i_b == '0);
    assign o_fast_result = !i_op[2] ? '0 : i_b == '0 ? (i_op[1] ? i_a : '1) : (i_op[1] ? '0 : i_a);
`else
    assign o_fast        = 1'b0;
    assign o_fast_result = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_neg   <= 1'b0;
            r_a_neg <= 1'b0;
            r_dz    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_op    <= i_op;
            r_neg   <= w_an ^ w_bn;
            r_a_neg <= w_an;
            r_dz    <= i_b == '0;
            r_a     <= i_a;
            r_b     <= w_mag_b;
            r_hi    <= '0;
            r_lo    <= w_mag_a;
            r_cnt   <= '0;
        end else if (i_step) begin
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
            r_cnt   <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ula_mdu_control.sv
// ula_mdu_control: ALU-control decoder plus iterative RV32M unit that stalls the core while busy.
// Define ULA_MDU_SHORTCUT_EN to let divide-by-zero, signed overflow and zero multiplies skip iteration.
module ula_mdu_control
    import ula_mdu_control_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    ula_mdu_control_if.slave io_bus
);
    state_t          r_state, w_state_nxt;
    ula_op_t         w_ula_op;
    logic            w_mdu_sel, w_accept, w_last, w_fast;
    logic [XLEN-1:0] w_core_res, w_fast_res, r_result;

    assign w_mdu_sel = io_bus.ALUOp == ALUOP_RTYPE && io_bus.funct7 == F7_MULDIV;
    assign w_accept  = r_state == S_IDLE && io_bus.start && w_mdu_sel;

    always_comb begin
        w_ula_op = ULA_INV;
        if (io_bus.ALUOp == ALUOP_MEM)
            w_ula_op = ULA_ADD;
        else if (io_bus.ALUOp == ALUOP_BRANCH)
            w_ula_op = ULA_SUB;
        else if (io_bus.ALUOp == ALUOP_RTYPE && io_bus.funct7 == F7_BASE)
            w_ula_op = io_bus.funct3 == F3_ADDSUB ? ULA_ADD :
                       io_bus.funct3 == F3_AND    ? ULA_AND :
                       io_bus.funct3 == F3_OR     ? ULA_OR  : ULA_INV;
        else if (io_bus.ALUOp == ALUOP_RTYPE && io_bus.funct7 == F7_ALT && io_bus.funct3 == F3_ADDSUB)
            w_ula_op = ULA_SUB;
        else if (w_mdu_sel)
            w_ula_op = ULA_ADD;
    end

    ula_mdu_core #(.XLEN(XLEN)) u_core (
        .clk           (clk),
        .rst           (rst),
        .i_load        (w_accept),
        .i_step        (r_state == S_BUSY),
        .i_op          (io_bus.funct3),
        .i_a           (io_bus.op_a),
        .i_b           (io_bus.op_b),
        .o_last        (w_last),
        .o_fast        (w_fast),
        .o_result      (w_core_res),
        .o_fast_result (w_fast_res)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_fast ? S_DONE : S_BUSY;
            S_BUSY:  if (w_last) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result is captured on the edge that enters DONE, so it is valid while done is high
    always_ff @(posedge clk) begin
        if (rst)
            r_result <= '0;
        else if (w_accept && w_fast)
            r_result <= w_fast_res;
        else if (w_last)
            r_result <= w_core_res;
    end

    assign io_bus.ula_op     = w_ula_op;
    assign io_bus.mdu_sel    = w_mdu_sel;
    assign io_bus.stall      = w_accept || r_state == S_BUSY;
    assign io_bus.busy       = r_state == S_BUSY;
    assign io_bus.done       = r_state == S_DONE;
    assign io_bus.mdu_result = r_result;
endmodule

// File: tb/tb_ula_mdu_control.sv
// tb_ula_mdu_control: directed and randomized checks of decode, M-op results, latency and stall.
// Expected latency follows ULA_MDU_SHORTCUT_EN when the bench is built with it.
module tb_ula_mdu_control;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ula_mdu_control_if #(.XLEN(XLEN)) bus ();
    ula_mdu_control #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic            ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        logic [63:0]     p;
        case (f3)
            3'd0:    p = ua * ub;
            3'd1:    p = sa * sb;
            3'd2:    p = sa * longint'(ub);
            3'd3:    p = ua * ub;
            3'd4:    return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5:    return b == 0 ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6:    return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return b == 0 ? a : 32'(ua % ub);
        endcase
        return f3 == 3'd0 ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef ULA_MDU_SHORTCUT_EN
        if (f3[2])
            return (b == 0 || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : XLEN;
        return (a == 0 || b == 0) ? 0 : XLEN;
`else
        return XLEN;
`endif
    endfunction

    task automatic decode(input string tag, input logic [1:0] aluop, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [3:0] exp_op, input logic exp_sel);
        bus.ALUOp  = aluop;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.start  = 1'b0;
        #1;
        check({tag, "_ula_op"}, 64'(bus.ula_op), 64'(exp_op));
        check({tag, "_mdu_sel"}, 64'(bus.mdu_sel), 64'(exp_sel));
        check({tag, "_stall"}, 64'(bus.stall), 64'd0);
    endtask

    // Issues one M-op from IDLE; with hold set, start stays high with fresh operands throughout
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input bit hold);
        int lat = 0;
        int stalls = 1;
        int busys = 0;
        int exp_lat = exp_latency(f3, a, b);
        bus.ALUOp  = 2'b10;
        bus.funct7 = 7'b0000001;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        #1;
        check({tag, "_stall_accept"}, 64'(bus.stall), 64'd1);
        @(posedge clk);
        #1;
        bus.start = hold;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.stall === 1'b1) stalls++;
            if (bus.busy === 1'b1) busys++;
            if (hold) begin
                bus.op_a   = $urandom;
                bus.op_b   = $urandom;
                bus.funct3 = 3'($urandom_range(0, 7));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat + 1));
        check({tag, "_busy_cycles"}, 64'(busys), 64'(exp_lat));
        check({tag, "_result"}, 64'(bus.mdu_result), 64'(exp_res));
        check({tag, "_stall_done"}, 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_result_hold"}, 64'(bus.mdu_result), 64'(exp_res));
    endtask

    initial begin
        int seen;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        bus.ALUOp  = 2'b00;
        bus.funct3 = 3'b000;
        bus.funct7 = 7'b0000000;
        bus.start  = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_result", 64'(bus.mdu_result), 64'd0);
        rst = 1'b0;

        decode("dec_ld", 2'b00, 3'b101, 7'b1111111, 4'b0010, 1'b0);
        decode("dec_br", 2'b01, 3'b000, 7'b0000000, 4'b0110, 1'b0);
        decode("dec_add", 2'b10, 3'b000, 7'b0000000, 4'b0010, 1'b0);
        decode("dec_sub", 2'b10, 3'b000, 7'b0100000, 4'b0110, 1'b0);
        decode("dec_and", 2'b10, 3'b111, 7'b0000000, 4'b0000, 1'b0);
        decode("dec_or", 2'b10, 3'b110, 7'b0000000, 4'b0001, 1'b0);
        decode("dec_sll", 2'b10, 3'b001, 7'b0000000, 4'b1111, 1'b0);
        decode("dec_alt_bad", 2'b10, 3'b111, 7'b0100000, 4'b1111, 1'b0);
        decode("dec_rsvd", 2'b11, 3'b000, 7'b0000000, 4'b1111, 1'b0);
        decode("dec_muldiv", 2'b10, 3'b100, 7'b0000001, 4'b0010, 1'b1);

        bus.ALUOp  = 2'b10;
        bus.funct7 = 7'b0000000;
        bus.start  = 1'b1;
        #1;
        check("nonm_start_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("nonm_start_busy", 64'(bus.busy), 64'd0);

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mul_zero", 3'd0, 32'd0, 32'h1234_5678, 32'h0, 1'b0);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
        run_op("divu_by0", 3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("remu_by0", 3'd7, 32'h1234, 32'd0, 32'h1234, 1'b0);
        run_op("div_by0_neg", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_by0_neg", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);

        bus.funct3 = 3'd0;
        bus.op_a   = 32'd5;
        bus.op_b   = 32'd6;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_stall", 64'(bus.stall), 64'd0);
        check("rst_mid_done", 64'(bus.done), 64'd0);
        check("rst_mid_result", 64'(bus.mdu_result), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen++;
        end
        check("rst_mid_no_done", 64'(seen), 64'd0);
        run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

        run_op("start_held", 3'd5, 32'd1000, 32'd9, 32'd111, 1'b1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen++;
        end
        check("start_held_single_done", 64'(seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       ra = 32'h0;
                1:       ra = 32'hFFFF_FFFF;
                2:       ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            run_op("rand", rf3, ra, rb, ref_mdu(rf3, ra, rb), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ula_mdu_control.md
Name: ula_mdu_control

Overview:
- Successor to the combinational ALU-control decoder, generalised to XLEN and extended with RV32M.
- Decodes ALUOp/funct3/funct7 into the 4-bit ula_op for the base ALU.
- Also runs M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) on an iterative multiply/divide datapath.
- Drives a stall to the single-cycle core while busy.

Parameters:
- XLEN, 32, operand/result width; legal values 8..64, even.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- ALUOp  input  2  00 load/store, 01 branch, 10 R-format, 11 reserved.
- funct3  input  3  instruction funct3.
- funct7  input  7  instruction funct7.
- start  input  1  instruction valid this cycle.
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value.
- ula_op  output  4  base ALU opcode, combinational.
- mdu_sel  output  1  current instruction is M-extension, combinational; core selects mdu_result.
- stall  output  1  hold PC/pipeline.
- busy  output  1  MDU iterating.
- done  output  1  one-cycle pulse, mdu_result valid.
- mdu_result  output  XLEN  M-op result.

Behaviour:
- Reset: ula_op decode stays combinational; busy=0, done=0, mdu_result=0; state=IDLE, counter=0.
- ula_op decode:
  - ALUOp=00 -> 0010 (add).
  - ALUOp=01 -> 0110 (sub).
  - ALUOp=10 with funct7=0000000: funct3 000 -> 0010, 111 -> 0000, 110 -> 0001.
  - ALUOp=10 with funct7=0100000 and funct3=000 -> 0110.
  - ALUOp=10 with funct7=0000001 -> 0010; result ignored by the core.
  - Any other combination -> 1111 (invalid).
- mdu_sel = (ALUOp==10) && (funct7==0000001).
- FSM IDLE -> BUSY -> DONE -> IDLE.
  - IDLE: start&&mdu_sel at edge k latches operands, op and signs; counter=0; go BUSY.
  - BUSY: one radix-2 step per cycle (shift-add multiply; restoring divide on magnitudes). After XLEN steps go DONE, so busy is high XLEN cycles.
  - DONE: done=1 for exactly one cycle; mdu_result registered with the final, sign-corrected value; return IDLE. mdu_result holds until the next accepted op or reset.
- Latency: accepted at edge k -> done high during cycle k+XLEN+1.
- stall = (state==IDLE && start && mdu_sel) || state==BUSY. Deasserts in the DONE cycle so the core retires the instruction with mdu_result.
- start while BUSY or DONE is ignored; no queueing.
- Multiply: 2·XLEN-bit product. MUL returns the low half; MULH/MULHSU/MULHU return the high half with signed×signed / signed×unsigned / unsigned×unsigned operands.
- Signed ops work on magnitudes, then fix up the sign:
  - Quotient is negated iff signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero: quotient = all ones; remainder = op_a.
- Signed overflow (op_a = most-negative, op_b = -1): quotient = op_a; remainder = 0.
- Reset mid-operation: next cycle is IDLE, busy=0, done=0, mdu_result=0; the partial op is discarded.
- start with mdu_sel=0: FSM unaffected, stall=0.

Optional Feature:
- Macro ULA_MDU_SHORTCUT_EN.
- Defined: divide-by-zero, signed overflow, and multiply with either operand 0 skip BUSY. Path is IDLE -> DONE, so done is high in cycle k+1 and stall lasts 1 cycle.
- Undefined: every M-op takes the full XLEN iterations. Results are bit-identical either way; only latency differs.

Decomposition:
- Shared package: ula_op codes (ULA_AND=0000, ULA_OR=0001, ULA_ADD=0010, ULA_SUB=0110, ULA_INV=1111), ALUOp codes, funct7 constants (F7_BASE, F7_ALT, F7_MULDIV), M-op funct3 codes, FSM state encoding.
- One sub-module: ula_mdu_core (iterative datapath + counter). The top holds the decoder, FSM, stall and result register.

Test Plan:
- Decode: ALUOp 00/01 -> 0010/0110; 10+000+0000000 -> 0010; 10+000+0100000 -> 0110; 10+111 -> 0000; 10+110 -> 0001; 10+001+0000000 -> 1111; 11 -> 1111; no start -> stall=0.
- MUL 7 × 0xFFFFFFFD -> 0xFFFFFFEB, done exactly at cycle k+33, stall high 33 cycles; MULHU 0xFFFFFFFF² -> 0xFFFFFFFE; MULH 0x80000000² -> 0x40000000.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. With ULA_MDU_SHORTCUT_EN, done at k+1.
- rst at BUSY cycle 10 -> next cycle busy=0, stall=0, mdu_result=0, no done pulse; new MUL 3×4 then -> 12.
- start pulsed every cycle during BUSY -> only the first op executes; single done pulse.
